clkdiv_ctrl: RTL and testbench

//   Run-time controller for the free-running mclk divider.
//   - Programmable divisor replaces the fixed counter-bit tap.
//   - Start/stop control.
//   - Valid/ready config handshake; a new divisor is applied only at a period boundary,
//     so the divided output never glitches.
//   - Outputs: a 1-cycle tick enable and a 50% square wave.
//   - Feeds slow-rate logic (display scan, LED blink, debounce) in the top level.

---
 rtl/clkdiv_ctrl.sv | 141 ++++++++++++++
 tb/tb_clkdiv_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/clkdiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clkdiv_ctrl
// Brief    : Run-time mclk divider with start/stop control, a glitch-free
//            divisor update handshake, a one-cycle tick and a 50% square wave.
// Revision : 1.0 - initial release
// ============================================================================
module clkdiv_ctrl #(
    parameter int CNT_W   = 29,
    parameter int DEF_DIV = 2**26
) (
    input  logic             mclk,
    input  logic             clr,
    input  logic             start,
    input  logic             stop,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic [CNT_W-1:0] div_cur,
    output logic             tick,
    output logic             clk_sq,
    output logic             running
);

    localparam logic [CNT_W-1:0] c_def_div = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_PEND = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] w_div_nxt;
    logic [CNT_W-1:0] r_pend;
    logic [CNT_W-1:0] w_pend_nxt;
    logic             r_tick;
    logic             w_tick_nxt;
    logic             r_sq;
    logic             w_sq_nxt;
    logic             r_run;

    logic             w_hs;
    logic [CNT_W-1:0] w_cfg_val;
    logic             w_wrap;

    assign cfg_ready = (r_state != S_PEND);
    assign w_hs      = cfg_valid && cfg_ready;
    assign w_cfg_val = (cfg_div == '0) ? c_one : cfg_div;
    assign w_wrap    = (r_cnt == (r_div - c_one));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_div_nxt   = r_div;
        w_pend_nxt  = r_pend;
        w_tick_nxt  = 1'b0;
        w_sq_nxt    = r_sq;

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                w_sq_nxt  = 1'b0;
                if (w_hs) begin
                    w_div_nxt = w_cfg_val;
                end
                if (start && !stop) begin
                    w_state_nxt = S_RUN;
                end
            end

            S_RUN, S_PEND: begin
                if (stop) begin
                    // Stop beats a coincident wrap: no tick, square wave parked low.
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_sq_nxt    = 1'b0;
                    if (r_state == S_PEND) begin
                        w_div_nxt = r_pend;
                    end else if (w_hs) begin
                        w_div_nxt = w_cfg_val;
                    end
                end else begin
                    if (w_wrap) begin
                        w_cnt_nxt  = '0;
                        w_tick_nxt = 1'b1;
                        w_sq_nxt   = ~r_sq;
                        if (r_state == S_PEND) begin
                            w_div_nxt   = r_pend;
                            w_state_nxt = S_RUN;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + c_one;
                    end
                    if ((r_state == S_RUN) && w_hs) begin
                        w_pend_nxt  = w_cfg_val;
                        w_state_nxt = S_PEND;
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_sq_nxt    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge mclk or posedge clr) begin
        if (clr) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_div   <= c_def_div;
            r_pend  <= '0;
            r_tick  <= 1'b0;
            r_sq    <= 1'b0;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_div   <= w_div_nxt;
            r_pend  <= w_pend_nxt;
            r_tick  <= w_tick_nxt;
            r_sq    <= w_sq_nxt;
            r_run   <= (w_state_nxt != S_IDLE);
        end
    end

    assign div_cur = r_div;
    assign tick    = r_tick;
    assign clk_sq  = r_sq;
    assign running = r_run;

endmodule
`default_nettype wire

// File: tb/tb_clkdiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clkdiv_ctrl
// Brief    : Directed self-checking bench for clkdiv_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clkdiv_ctrl;

    localparam int               CNT_W  = 29;
    localparam logic [CNT_W-1:0] DEFDIV = 29'd67108864;
    localparam logic [CNT_W-1:0] MAXDIV = '1;

    logic             mclk;
    logic             clr;
    logic             start;
    logic             stop;
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ready;
    logic [CNT_W-1:0] div_cur;
    logic             tick;
    logic             clk_sq;
    logic             running;

    int checks = 0;
    int errors = 0;

    clkdiv_ctrl #(.CNT_W(CNT_W), .DEF_DIV(2**26)) dut (
        .mclk      (mclk),
        .clr       (clr),
        .start     (start),
        .stop      (stop),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .div_cur   (div_cur),
        .tick      (tick),
        .clk_sq    (clk_sq),
        .running   (running)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge mclk);
        #1;
    endtask

    task automatic load_div(input logic [CNT_W-1:0] d);
        cfg_valid = 1'b1;
        cfg_div   = d;
        step();
        cfg_valid = 1'b0;
        cfg_div   = '0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b1; start = 1'b0; stop = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
        #2;
        checks++; if (div_cur !== DEFDIV) begin errors++; $display("FAIL rst_div got %0d exp %0d", div_cur, DEFDIV); end
        checks++; if ({tick, clk_sq, running} !== 3'b000) begin errors++; $display("FAIL rst_outs got %b exp 000", {tick, clk_sq, running}); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", cfg_ready); end
        step();
        step();
        clr = 1'b0;
        step();
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL rst_idle got %b exp 0", running); end
    endtask

    task automatic test_basic();
        logic e_tick, e_sq;
        load_div(29'd4);
        checks++; if (div_cur !== 29'd4) begin errors++; $display("FAIL basic_div got %0d exp 4", div_cur); end
        do_start();
        checks++; if ({running, tick, clk_sq} !== 3'b100) begin errors++; $display("FAIL basic_start got %b exp 100", {running, tick, clk_sq}); end
        for (int n = 1; n <= 12; n++) begin
            step();
            e_tick = (n % 4 == 0);
            e_sq   = ((n / 4) % 2 == 1);
            checks++; if (tick !== e_tick) begin errors++; $display("FAIL basic_tick n=%0d got %b exp %b", n, tick, e_tick); end
            checks++; if (clk_sq !== e_sq) begin errors++; $display("FAIL basic_sq n=%0d got %b exp %b", n, clk_sq, e_sq); end
        end
        do_stop();
        checks++; if ({running, clk_sq} !== 2'b00) begin errors++; $display("FAIL basic_stop got %b exp 00", {running, clk_sq}); end
    endtask

    task automatic test_update();
        logic             e_tick, e_rdy;
        logic [CNT_W-1:0] e_div;
        load_div(29'd5);
        do_start();
        step();
        cfg_valid = 1'b1;
        cfg_div   = 29'd3;
        step();
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL upd_ready_low got %b exp 0", cfg_ready); end
        for (int n = 3; n <= 12; n++) begin
            cfg_valid = (n >= 3 && n <= 5);
            cfg_div   = 29'd7;
            step();
            e_tick = (n == 5 || n == 8 || n == 11);
            e_rdy  = (n >= 5);
            e_div  = (n >= 5) ? 29'd3 : 29'd5;
            checks++; if (tick !== e_tick) begin errors++; $display("FAIL upd_tick n=%0d got %b exp %b", n, tick, e_tick); end
            checks++; if (cfg_ready !== e_rdy) begin errors++; $display("FAIL upd_ready n=%0d got %b exp %b", n, cfg_ready, e_rdy); end
            checks++; if (div_cur !== e_div) begin errors++; $display("FAIL upd_div n=%0d got %0d exp %0d", n, div_cur, e_div); end
        end
        cfg_valid = 1'b0;
        do_stop();
    endtask

    task automatic test_edge_divisors();
        load_div(29'd0);
        checks++; if (div_cur !== 29'd1) begin errors++; $display("FAIL edge_zero_div got %0d exp 1", div_cur); end
        do_start();
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL edge_first_tick got %b exp 0", tick); end
        for (int n = 1; n <= 6; n++) begin
            step();
            checks++; if (tick !== 1'b1) begin errors++; $display("FAIL edge_tick n=%0d got %b exp 1", n, tick); end
            checks++; if (clk_sq !== n[0]) begin errors++; $display("FAIL edge_sq n=%0d got %b exp %b", n, clk_sq, n[0]); end
        end
        do_stop();
        checks++; if ({tick, clk_sq} !== 2'b00) begin errors++; $display("FAIL edge_stop got %b exp 00", {tick, clk_sq}); end
        load_div(MAXDIV);
        checks++; if (div_cur !== MAXDIV) begin errors++; $display("FAIL edge_max_div got %0h exp %0h", div_cur, MAXDIV); end
        do_start();
        for (int n = 1; n <= 4; n++) step();
        checks++; if ({running, tick} !== 2'b10) begin errors++; $display("FAIL edge_max_run got %b exp 10", {running, tick}); end
        do_stop();
    endtask

    task automatic test_stop_simultaneous();
        load_div(29'd4);
        do_start();
        for (int n = 1; n <= 3; n++) step();
        checks++; if ({running, tick} !== 2'b10) begin errors++; $display("FAIL stopw_pre got %b exp 10", {running, tick}); end
        do_stop();
        checks++; if ({running, tick, clk_sq} !== 3'b000) begin errors++; $display("FAIL stopw_wrap got %b exp 000", {running, tick, clk_sq}); end
        start = 1'b1; stop = 1'b1;
        step();
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL stopw_both got %b exp 0", running); end
        start = 1'b0; stop = 1'b0;
        step();
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL stopw_both2 got %b exp 0", running); end
        load_div(29'd5);
        do_start();
        step();
        cfg_valid = 1'b1; cfg_div = 29'd7; stop = 1'b1;
        step();
        cfg_valid = 1'b0; stop = 1'b0;
        checks++; if (div_cur !== 29'd7) begin errors++; $display("FAIL stopcfg_div got %0d exp 7", div_cur); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL stopcfg_run got %b exp 0", running); end
    endtask

    task automatic test_stop_pend();
        logic e_tick, e_sq;
        load_div(29'd6);
        do_start();
        step();
        cfg_valid = 1'b1; cfg_div = 29'd2;
        step();
        cfg_valid = 1'b0;
        checks++; if ({cfg_ready, div_cur} !== {1'b0, 29'd6}) begin errors++; $display("FAIL pend_hold got %b/%0d exp 0/6", cfg_ready, div_cur); end
        do_stop();
        checks++; if (div_cur !== 29'd2) begin errors++; $display("FAIL pend_stop_div got %0d exp 2", div_cur); end
        checks++; if ({running, cfg_ready} !== 2'b01) begin errors++; $display("FAIL pend_stop_st got %b exp 01", {running, cfg_ready}); end
        do_start();
        for (int n = 1; n <= 6; n++) begin
            step();
            e_tick = (n % 2 == 0);
            e_sq   = ((n / 2) % 2 == 1);
            checks++; if (tick !== e_tick) begin errors++; $display("FAIL pend_tick n=%0d got %b exp %b", n, tick, e_tick); end
            checks++; if (clk_sq !== e_sq) begin errors++; $display("FAIL pend_sq n=%0d got %b exp %b", n, clk_sq, e_sq); end
        end
        do_stop();
    endtask

    task automatic test_reset_midrun();
        load_div(29'd3);
        do_start();
        for (int n = 1; n <= 3; n++) step();
        checks++; if ({tick, clk_sq, running} !== 3'b111) begin errors++; $display("FAIL mid_pre got %b exp 111", {tick, clk_sq, running}); end
        #2 clr = 1'b1;
        #1;
        checks++; if ({tick, clk_sq, running} !== 3'b000) begin errors++; $display("FAIL mid_async got %b exp 000", {tick, clk_sq, running}); end
        checks++; if (div_cur !== DEFDIV) begin errors++; $display("FAIL mid_div got %0d exp %0d", div_cur, DEFDIV); end
        clr = 1'b0;
        step();
        checks++; if ({running, cfg_ready} !== 2'b01) begin errors++; $display("FAIL mid_after got %b exp 01", {running, cfg_ready}); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_update();
        test_edge_divisors();
        test_stop_simultaneous();
        test_stop_pend();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
